icache_fetch: RTL and testbench
===============================

ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped 128-bit lines; power of two, at least 2.
REQ-002 SHALL have parameter MEM_LAT_MAX, default 15, watchdog limit in cycles per refill beat.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_pc_in  input  32  fetch line address from the instruction queue; bits [3:0] ignored.
REQ-006 SHALL have port i_rd_en  input  1  fetch request, sampled only when o_ready=1.
REQ-007 SHALL have port i_abort  input  1  branch/jump flush.
REQ-008 SHALL have port o_ready  output  1  high only in IDLE.
REQ-009 SHALL have port o_dout  output  128  fetched line; word k at bits [32k+31:32k].
REQ-010 SHALL have port o_dout_valid  output  1  one-cycle line-valid strobe to the queue write side.
REQ-011 SHALL have port o_mem_req  output  1  memory beat request.
REQ-012 SHALL have port o_mem_addr  output  32  word-aligned beat address.
REQ-013 SHALL have port i_mem_ack  input  1  beat complete; i_mem_rdata is valid in the same cycle.
REQ-014 SHALL have port i_mem_rdata  input  32  beat data.
REQ-015 SHALL have port o_err  output  1  sticky watchdog-timeout flag.

Function
REQ-016 SHALL split addresses as index = i_pc_in[4+log2(LINES)-1:4] and tag = the remaining upper bits.
REQ-017 SHALL use FSM states IDLE, REFILL, RESPOND.
REQ-018 SHALL, in IDLE with i_rd_en=1, i_abort=0 and a hit (valid and tag match), drive o_dout_valid=1 with the line on the next cycle and stay in IDLE (1-cycle latency).
REQ-019 SHALL, on a miss, latch the line address and go to REFILL; o_mem_req rises the next cycle.
REQ-020 SHALL issue 4 beats in REFILL at base+0, +4, +8, +12, in that order, with one beat outstanding.
REQ-021 SHALL hold o_mem_req and o_mem_addr stable until i_mem_ack, and drop o_mem_req for 1 cycle between beats.
REQ-022 SHALL store each acked word at its slot; after the 4th ack go to RESPOND.
REQ-023 SHALL, in RESPOND, write data, tag and valid to the line, pulse o_dout_valid with the line, and return to IDLE.
REQ-024 SHALL give priority to i_abort over i_rd_en in the same cycle: no lookup, no request, no strobe.
REQ-025 SHALL, on i_abort in REFILL with no beat pending, drop o_mem_req and return to IDLE next cycle with no line write and no strobe.
REQ-026 SHALL, on i_abort in REFILL with a beat pending, complete that beat first, then return to IDLE with the line discarded.
REQ-027 SHALL, on i_abort in RESPOND, suppress o_dout_valid but still write the line.
REQ-028 SHALL ignore i_rd_en while o_ready=0.
REQ-029 SHALL, on a watchdog timeout (beat pending longer than MEM_LAT_MAX cycles), set o_err, drop o_mem_req and return to IDLE with no line write.
REQ-030 SHALL drive o_dout=0 whenever o_dout_valid=0.

Reset
REQ-031 SHALL, on i_rst, clear all valid bits, set state IDLE, and zero o_dout_valid, o_mem_req, o_mem_addr, o_dout and o_err.
REQ-032 SHALL, on i_rst mid-refill, drop o_mem_req the next cycle and ignore any later ack from the abandoned beat.

Configuration
REQ-033 SHALL, with ICACHE_STATS_EN defined, add outputs o_hit_cnt and o_miss_cnt (16 bits each, saturating, cleared by i_rst) counting accepted non-aborted lookups.
REQ-034 SHALL, without ICACHE_STATS_EN, have neither those ports nor the counter logic.

Structure
REQ-035 SHALL define, in shared package riscv_fetch_pkg, the state enum, LINE_W=128 and WORDS_PER_LINE=4.
REQ-036 SHALL hold data, tag and valid storage in sub-module icache_line_mem (read-async, write-sync, synchronous valid clear).

Verification
REQ-037 SHALL cover a cold miss: rd_en at pc 0x0000_0040, ack each beat 2 cycles later -> beats at 0x40, 0x44, 0x48, 0x4C, then one o_dout_valid with the 4 words assembled.
REQ-038 SHALL cover a re-fetch: rd_en at 0x40 after the fill -> o_dout_valid the next cycle and o_mem_req stays 0.
REQ-039 SHALL cover a conflict: with LINES=16, fetch 0x40 then 0x140 -> the second fetch misses, and re-fetching 0x40 misses again.
REQ-040 SHALL cover abort with a beat pending: abort during beat 2 of a refill at 0x80 -> beat 2 completes, no strobe, o_ready=1, and the next fetch of 0x80 misses.
REQ-041 SHALL cover abort and rd_en in the same cycle -> no mem request and no strobe.
REQ-042 SHALL cover a timeout: no ack for 16 cycles -> o_err=1, o_mem_req=0, state IDLE; i_rst clears o_err.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// riscv_fetch_pkg: shared fetch-path types and line geometry.
// Rev 1.0
// ============================================================================
package riscv_fetch_pkg;

  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    RESPOND = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/icache_line_mem.sv
`default_nettype none
// ============================================================================
// icache_line_mem: direct-mapped line storage, async read, sync write/valid clear.
// Rev 1.0
// ============================================================================
module icache_line_mem #(
  parameter int LINES  = 16,
  parameter int TAG_W  = 24,
  parameter int LINE_W = 128,
  parameter int IDX_W  = $clog2(LINES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [LINE_W-1:0] o_rd_data,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic              o_rd_valid,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_data
);

  logic [LINE_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  // Data and tag arrays carry no reset; the valid vector alone gates hits.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      data_q[i_wr_idx] <= i_wr_data;
      tag_q[i_wr_idx]  <= i_wr_tag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
    end else if (i_we) begin
      valid_q[i_wr_idx] <= 1'b1;
    end
  end

  assign o_rd_data  = data_q[i_rd_idx];
  assign o_rd_tag   = tag_q[i_rd_idx];
  assign o_rd_valid = valid_q[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
// icache_fetch: direct-mapped I-cache line fetch with 4-beat refill and watchdog.
// Optional ICACHE_STATS_EN adds saturating hit/miss counters.  Rev 1.0
// ============================================================================
module icache_fetch
  import riscv_fetch_pkg::*;
#(
  parameter int LINES       = 16,
  parameter int MEM_LAT_MAX = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_pc_in,
  input  logic              i_rd_en,
  input  logic              i_abort,
  output logic              o_ready,
  output logic [LINE_W-1:0] o_dout,
  output logic              o_dout_valid,
  output logic              o_mem_req,
  output logic [31:0]       o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_err
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]       o_hit_cnt,
  output logic [15:0]       o_miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;
  localparam int WD_W  = $clog2(MEM_LAT_MAX + 2);

  fetch_state_e state_q, state_d;
  logic [27:0]       line_addr_q, line_addr_d;
  logic [1:0]        beat_q, beat_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic              abort_pend_q, abort_pend_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic [WORDS_PER_LINE-1:0][31:0] words_q, words_d;
  logic              dout_valid_q, dout_valid_d;
  logic [LINE_W-1:0] dout_q, dout_d;
  logic              w_we;

  logic [LINE_W-1:0] w_rd_data;
  logic [TAG_W-1:0]  w_rd_tag;
  logic              w_rd_valid;
  logic              w_hit;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^i_pc_in[3:0];

  icache_line_mem #(
    .LINES  (LINES),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) u_line_mem (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rd_idx   (i_pc_in[4 +: IDX_W]),
    .o_rd_data  (w_rd_data),
    .o_rd_tag   (w_rd_tag),
    .o_rd_valid (w_rd_valid),
    .i_we       (w_we),
    .i_wr_idx   (line_addr_q[IDX_W-1:0]),
    .i_wr_tag   (line_addr_q[27:IDX_W]),
    .i_wr_data  (words_q)
  );

  assign w_hit = w_rd_valid && (w_rd_tag == i_pc_in[31:4+IDX_W]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      line_addr_q  <= '0;
      beat_q       <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      abort_pend_q <= 1'b0;
      wd_q         <= '0;
      err_q        <= 1'b0;
      words_q      <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      beat_q       <= beat_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      abort_pend_q <= abort_pend_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      words_q      <= words_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    beat_d       = beat_q;
    req_d        = req_q;
    addr_d       = addr_q;
    abort_pend_d = abort_pend_q;
    wd_d         = wd_q;
    err_d        = err_q;
    words_d      = words_q;
    dout_valid_d = 1'b0;
    dout_d       = '0;
    w_we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_rd_en && !i_abort) begin
          if (w_hit) begin
            dout_valid_d = 1'b1;
            dout_d       = w_rd_data;
          end else begin
            line_addr_d  = i_pc_in[31:4];
            beat_d       = '0;
            req_d        = 1'b1;
            addr_d       = {i_pc_in[31:4], 4'h0};
            wd_d         = '0;
            abort_pend_d = 1'b0;
            state_d      = REFILL;
          end
        end
      end
      REFILL: begin
        if (req_q) begin
          // An abort while a beat is outstanding is remembered until that beat completes.
          if (i_abort) abort_pend_d = 1'b1;
          if (i_mem_ack) begin
            words_d[beat_q] = i_mem_rdata;
            req_d           = 1'b0;
            wd_d            = '0;
            if (abort_pend_q || i_abort) begin
              abort_pend_d = 1'b0;
              state_d      = IDLE;
            end else if (beat_q == 2'd3) begin
              state_d = RESPOND;
            end else begin
              beat_d = beat_q + 2'd1;
            end
          end else if (wd_q == WD_W'(MEM_LAT_MAX)) begin
            err_d        = 1'b1;
            req_d        = 1'b0;
            abort_pend_d = 1'b0;
            state_d      = IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end else if (i_abort) begin
          state_d = IDLE;
        end else begin
          req_d  = 1'b1;
          addr_d = {line_addr_q, beat_q, 2'b00};
        end
      end
      RESPOND: begin
        w_we         = 1'b1;
        dout_valid_d = !i_abort;
        dout_d       = i_abort ? '0 : words_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE && i_rd_en && !i_abort) begin
      if (w_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

  assign o_ready      = (state_q == IDLE);
  assign o_dout       = dout_q;
  assign o_dout_valid = dout_valid_q;
  assign o_mem_req    = req_q;
  assign o_mem_addr   = addr_q;
  assign o_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// ============================================================================
// tb_icache_fetch: scoreboard bench for icache_fetch (beat addresses and lines).
// Rev 1.0
// ============================================================================
module tb_icache_fetch;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  pc = '0;
  logic         rd_en = 1'b0;
  logic         abort = 1'b0;
  logic         ready;
  logic [127:0] dout;
  logic         dout_valid;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         err;

  int tests = 0;
  int fails = 0;
  int rise_cnt = 0;
  int strobe_cnt = 0;
  int ack_cnt = 0;
  int ack_delay = 2;
  bit mem_on = 1'b1;

  logic [31:0]  exp_addr [$];
  logic [127:0] exp_line [$];

  always #5 clk = ~clk;

  icache_fetch #(.LINES(16), .MEM_LAT_MAX(15)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pc_in      (pc),
    .i_rd_en      (rd_en),
    .i_abort      (abort),
    .o_ready      (ready),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata),
    .o_err        (err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'h0};
    return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
  endfunction

  // Memory model: acks a held request ack_delay cycles after it is first seen.
  initial begin : responder
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req && mem_on && !rst) begin
        wcnt++;
        if (wcnt >= ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = mem_word(mem_addr);
          ack_cnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: beat-address and line scoreboards, address stability, zero idle data.
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    logic [31:0]  ea;
    logic [127:0] el;
    if (!rst) begin
      if (mem_req && !prev_req) begin
        rise_cnt++;
        tests++;
        if (exp_addr.size() == 0) begin
          fails++;
          $display("FAIL beat_addr: unexpected request at %h", mem_addr);
        end else begin
          ea = exp_addr.pop_front();
          if (mem_addr !== ea) begin
            fails++;
            $display("FAIL beat_addr: got %h expected %h", mem_addr, ea);
          end
        end
      end else if (mem_req && prev_req) begin
        tests++;
        if (mem_addr !== prev_addr) begin
          fails++;
          $display("FAIL addr_stable: got %h expected %h", mem_addr, prev_addr);
        end
      end
      tests++;
      if (dout_valid) begin
        strobe_cnt++;
        if (exp_line.size() == 0) begin
          fails++;
          $display("FAIL line: unexpected strobe with %h", dout);
        end else begin
          el = exp_line.pop_front();
          if (dout !== el) begin
            fails++;
            $display("FAIL line: got %h expected %h", dout, el);
          end
        end
      end else if (dout !== '0) begin
        fails++;
        $display("FAIL dout_zero: got %h expected 0", dout);
      end
    end
    prev_req  = mem_req;
    prev_addr = mem_addr;
  end

  task automatic push_miss(input logic [31:0] a);
    for (int k = 0; k < 4; k++) exp_addr.push_back({a[31:4], 4'h0} + 32'(4 * k));
    exp_line.push_back(line_of(a));
  endtask

  task automatic issue_fetch(input logic [31:0] a);
    for (int i = 0; i < 100 && !ready; i++) begin
      @(posedge clk);
      #1;
    end
    pc = a;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic wait_strobe(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (strobe_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (ready !== 1'b1)     begin fails++; $display("FAIL reset_ready: got %b expected 1", ready); end
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    tests++; if (mem_addr !== '0)    begin fails++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    tests++; if (dout !== '0)        begin fails++; $display("FAIL reset_dout: got %h expected 0", dout); end
    tests++; if (err !== 1'b0)       begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_miss(input logic [31:0] a, input string name);
    int r0, s0;
    bit ok;
    r0 = rise_cnt;
    s0 = strobe_cnt;
    push_miss(a);
    issue_fetch(a);
    tests++;
    if (mem_req !== 1'b1) begin fails++; $display("FAIL %s_req_rise: got %b expected 1", name, mem_req); end
    wait_strobe(s0 + 1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL %s_timeout: strobes %0d expected %0d", name, strobe_cnt, s0 + 1); end
    tests++; if (rise_cnt !== r0 + 4) begin fails++; $display("FAIL %s_beats: got %0d expected %0d", name, rise_cnt - r0, 4); end
    tests++; if (exp_addr.size() != 0) begin fails++; $display("FAIL %s_addr_left: got %0d expected 0", name, exp_addr.size()); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL %s_ready: got %b expected 1", name, ready); end
  endtask

  task automatic test_back_to_back;
    int r0, s0;
    r0 = rise_cnt;
    s0 = strobe_cnt;
    exp_line.push_back(line_of(32'h40));
    exp_line.push_back(line_of(32'h4C));
    pc = 32'h40;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL hit1_valid: got %b expected 1", dout_valid); end
    pc = 32'h4C;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL hit2_valid: got %b expected 1", dout_valid); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rise_cnt !== r0) begin fails++; $display("FAIL hit_no_req: got %0d expected 0", rise_cnt - r0); end
    tests++; if (strobe_cnt !== s0 + 2) begin fails++; $display("FAIL hit_strobes: got %0d expected 2", strobe_cnt - s0); end
  endtask

  task automatic test_abort_pending;
    int r0, s0, a0;
    r0 = rise_cnt;
    s0 = strobe_cnt;
    a0 = ack_cnt;
    ack_delay = 4;
    exp_addr.push_back(32'h80);
    exp_addr.push_back(32'h84);
    issue_fetch(32'h80);
    for (int i = 0; i < 50 && rise_cnt < r0 + 2; i++) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b expected 1", ready); end
    tests++; if (ack_cnt !== a0 + 2) begin fails++; $display("FAIL abort_acks: got %0d expected 2", ack_cnt - a0); end
    tests++; if (rise_cnt !== r0 + 2) begin fails++; $display("FAIL abort_beats: got %0d expected 2", rise_cnt - r0); end
    tests++; if (strobe_cnt !== s0) begin fails++; $display("FAIL abort_strobe: got %0d expected 0", strobe_cnt - s0); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL abort_req: got %b expected 0", mem_req); end
    ack_delay = 2;
    test_miss(32'h80, "abort_refetch");
  endtask

  task automatic test_abort_same_cycle;
    int r0, s0;
    r0 = rise_cnt;
    s0 = strobe_cnt;
    pc = 32'h200;
    rd_en = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++; if (rise_cnt !== r0) begin fails++; $display("FAIL same_abort_req: got %0d expected 0", rise_cnt - r0); end
    tests++; if (strobe_cnt !== s0) begin fails++; $display("FAIL same_abort_strobe: got %0d expected 0", strobe_cnt - s0); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL same_abort_ready: got %b expected 1", ready); end
  endtask

  task automatic test_timeout;
    int n;
    mem_on = 1'b0;
    exp_addr.push_back(32'h300);
    issue_fetch(32'h300);
    n = 0;
    while (!err && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++; if (n != 16) begin fails++; $display("FAIL wd_cycles: got %0d expected 16", n); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL wd_err: got %b expected 1", err); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL wd_req: got %b expected 0", mem_req); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL wd_ready: got %b expected 1", ready); end
    mem_on = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL wd_rst_err: got %b expected 0", err); end
    @(posedge clk);
    #1;
    test_miss(32'h40, "post_rst_miss");
  endtask

  initial begin
    test_reset();
    test_miss(32'h0000_0040, "cold_miss");
    test_back_to_back();
    test_miss(32'h0000_0140, "conflict");
    test_miss(32'h0000_0040, "conflict_back");
    test_abort_pending();
    test_abort_same_cycle();
    test_timeout();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (exp_line.size() != 0) begin fails++; $display("FAIL line_left: got %0d expected 0", exp_line.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
